// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types and constants for the PWM capture block
package pwm_pkg;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        ARM      = 2'd1,
        HIGH     = 2'd2,
        LOW      = 2'd3
    } pwm_state_e;

    localparam int DUTY_W   = 8;
    localparam int DIV_ITER = 8;

endpackage

// File: rtl/pwm_capture_if.sv
// rtl/pwm_capture_if.sv - control and measurement-result bundle of the PWM capture block
interface pwm_capture_if #(
    parameter int CNT_W = 16
);
    logic             en;
    logic             pwm_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic [7:0]       duty;
    logic             valid;
    logic             stuck;
    logic             stuck_level;
    logic             overrun;

    modport master (
        output en, pwm_in,
        input  period, high_time, duty, valid, stuck, stuck_level, overrun
    );

    modport slave (
        input  en, pwm_in,
        output period, high_time, duty, valid, stuck, stuck_level, overrun
    );
endinterface

// File: rtl/pwm_duty_divider.sv
// rtl/pwm_duty_divider.sv - restoring fractional divider, q = floor(num*256/den), one bit per clock
module pwm_duty_divider
    import pwm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  num,
    input  logic [CNT_W-1:0]  den,
    output logic              busy,
    output logic              done,
    output logic [DUTY_W-1:0] q
);
    localparam int IW = $clog2(DIV_ITER);

    logic [CNT_W:0]      rem_q;
    logic [CNT_W:0]      rem_shift;
    logic [CNT_W:0]      rem_next;
    logic [CNT_W-1:0]    den_q;
    logic [DUTY_W-1:0]   quo_q;
    logic [IW-1:0]       iter_q;
    logic                sat_q;
    logic                q_bit;

    // The remainder stays below den, so its shifted value always fits CNT_W+1 bits.
    always_comb begin
        rem_shift = {rem_q[CNT_W-1:0], 1'b0};
        q_bit     = (rem_shift >= {1'b0, den_q});
        rem_next  = q_bit ? (rem_shift - {1'b0, den_q}) : rem_shift;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            den_q  <= '0;
            quo_q  <= '0;
            iter_q <= '0;
            sat_q  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                busy   <= 1'b0;
                iter_q <= '0;
            end else if (start) begin
                rem_q  <= {1'b0, num};
                den_q  <= den;
                quo_q  <= '0;
                iter_q <= '0;
                sat_q  <= (num >= den);
                busy   <= 1'b1;
            end else if (busy) begin
                rem_q  <= rem_next;
                quo_q  <= {quo_q[DUTY_W-2:0], q_bit};
                iter_q <= iter_q + 1'b1;
                if (iter_q == IW'(DIV_ITER - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign q = sat_q ? '1 : quo_q;

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - measures period, high time and duty of one asynchronous PWM input
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    pwm_capture_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   synced_d;
    logic                   rise;
    logic                   fall;

    pwm_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CNT_W-1:0] hi_lat_q, hi_lat_d;
    logic [CNT_W-1:0] snap_per_q, snap_per_d;
    logic [CNT_W-1:0] snap_hi_q, snap_hi_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic             valid_q, valid_d;
    logic             stuck_q, stuck_d;
    logic             level_q, level_d;
    logic             ovr_q, ovr_d;
    logic             timeout;
    logic             to_fire;

    logic             div_start;
    logic             div_abort;
    logic             div_busy;
    logic             div_done;
    logic [DUTY_W-1:0] div_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            synced_d <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], bus.pwm_in};
            synced_d <= synced;
        end
    end

    assign synced  = sync_q[SYNC_STAGES-1];
    assign rise    = synced & ~synced_d;
    assign fall    = ~synced & synced_d;
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    // Once stuck is reported the counter may sit at its ceiling; only one report per stall.
    assign timeout = (cnt_q == CNT_MAX) && !stuck_q;

    pwm_duty_divider #(
        .CNT_W (CNT_W)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .start (div_start),
        .abort (div_abort),
        .num   (hi_lat_q),
        .den   (cnt_q),
        .busy  (div_busy),
        .done  (div_done),
        .q     (div_q)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_lat_d   = hi_lat_q;
        snap_per_d = snap_per_q;
        snap_hi_d  = snap_hi_q;
        period_d   = period_q;
        high_d     = high_q;
        duty_d     = duty_q;
        valid_d    = 1'b0;
        stuck_d    = stuck_q;
        level_d    = level_q;
        ovr_d      = ovr_q;
        div_start  = 1'b0;
        div_abort  = 1'b0;
        to_fire    = 1'b0;

        if (!bus.en) begin
            state_d   = DISABLED;
            cnt_d     = '0;
            div_abort = 1'b1;
            stuck_d   = 1'b0;
            ovr_d     = 1'b0;
        end else begin
            if (div_done) begin
                period_d = snap_per_q;
                high_d   = snap_hi_q;
                duty_d   = div_q;
                valid_d  = 1'b1;
            end
            if (rise) begin
                stuck_d = 1'b0;
            end

            unique case (state_q)
                DISABLED: begin
                    state_d = ARM;
                    cnt_d   = '0;
                end
                ARM: begin
                    if (rise) begin
                        state_d = HIGH;
                        cnt_d   = CNT_ONE;
                    end else if (timeout) begin
                        to_fire = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        hi_lat_d = cnt_q;
                        state_d  = LOW;
                        cnt_d    = cnt_inc;
                    end else if (timeout) begin
                        to_fire = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                LOW: begin
                    if (rise) begin
                        state_d = HIGH;
                        cnt_d   = CNT_ONE;
                        // A period ending while the divider works is dropped, not queued.
                        if (div_busy) begin
                            ovr_d = 1'b1;
                        end else begin
                            div_start  = 1'b1;
                            snap_per_d = cnt_q;
                            snap_hi_d  = hi_lat_q;
                        end
                    end else if (timeout) begin
                        to_fire = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: state_d = DISABLED;
            endcase

            if (to_fire) begin
                stuck_d  = 1'b1;
                level_d  = synced;
                period_d = '0;
                high_d   = '0;
                duty_d   = synced ? '1 : '0;
                valid_d  = 1'b1;
                state_d  = ARM;
                cnt_d    = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= DISABLED;
            cnt_q      <= '0;
            hi_lat_q   <= '0;
            snap_per_q <= '0;
            snap_hi_q  <= '0;
            period_q   <= '0;
            high_q     <= '0;
            duty_q     <= '0;
            valid_q    <= 1'b0;
            stuck_q    <= 1'b0;
            level_q    <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_lat_q   <= hi_lat_d;
            snap_per_q <= snap_per_d;
            snap_hi_q  <= snap_hi_d;
            period_q   <= period_d;
            high_q     <= high_d;
            duty_q     <= duty_d;
            valid_q    <= valid_d;
            stuck_q    <= stuck_d;
            level_q    <= level_d;
            ovr_q      <= ovr_d;
        end
    end

    assign bus.period      = period_q;
    assign bus.high_time   = high_q;
    assign bus.duty        = duty_q;
    assign bus.valid       = valid_q;
    assign bus.stuck       = stuck_q;
    assign bus.stuck_level = level_q;
    assign bus.overrun     = ovr_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - scoreboard bench for pwm_capture at CNT_W=8 and CNT_W=16
module tb_pwm_capture;

    localparam int IN_LAT  = 3;
    localparam int DIV_LAT = 9;
    localparam int MAX8    = 255;

    typedef struct {
        int   cyc;
        int   per;
        int   hi;
        int   duty;
        logic stk;
        logic lvl;
    } exp_t;

    logic clk;
    logic rst_n;
    logic pwm;
    logic en8;
    logic en16;
    int   cyc;
    int   n_cmp;
    int   n_err;

    exp_t exp_q[$];
    bit   armed;
    bit   exp_ovr;
    int   r_last;
    int   f_last;
    int   acc_last;

    pwm_capture_if #(.CNT_W(8))  if8 ();
    pwm_capture_if #(.CNT_W(16)) if16 ();

    assign if8.en      = en8;
    assign if8.pwm_in  = pwm;
    assign if16.en     = en16;
    assign if16.pwm_in = pwm;

    pwm_capture #(.CNT_W(8), .SYNC_STAGES(2)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8.slave)
    );

    pwm_capture #(.CNT_W(16), .SYNC_STAGES(2)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if16.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic model_reset();
        armed    = 1'b0;
        exp_ovr  = 1'b0;
        acc_last = -1000;
    endtask

    // Called at the cycle a rise is driven; predicts the measurement it terminates.
    task automatic model_rise();
        exp_t e;
        if (armed) begin
            if (cyc - acc_last >= DIV_LAT) begin
                e.cyc  = cyc + IN_LAT + DIV_LAT;
                e.per  = cyc - r_last;
                e.hi   = f_last - r_last;
                e.duty = (e.hi * 256) / e.per;
                if (e.duty > 255) e.duty = 255;
                e.stk  = 1'b0;
                e.lvl  = 1'b0;
                exp_q.push_back(e);
                acc_last = cyc;
            end else begin
                exp_ovr = 1'b1;
            end
        end
        armed  = 1'b1;
        r_last = cyc;
    endtask

    task automatic tick();
        exp_t        e;
        logic        gv [2];
        logic [15:0] gp [2];
        logic [15:0] gh [2];
        logic [7:0]  gd [2];
        logic        gs [2];
        logic        gl [2];
        @(negedge clk);
        gv[0] = if8.valid;  gp[0] = {8'h00, if8.period}; gh[0] = {8'h00, if8.high_time};
        gd[0] = if8.duty;   gs[0] = if8.stuck;           gl[0] = if8.stuck_level;
        gv[1] = if16.valid; gp[1] = if16.period;         gh[1] = if16.high_time;
        gd[1] = if16.duty;  gs[1] = if16.stuck;          gl[1] = if16.stuck_level;
        for (int i = 0; i < 2; i++) begin
            if (gv[i] !== 1'b0) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_valid w%0d: got valid=%b at cyc %0d, required no pulse",
                             (i == 0) ? 8 : 16, gv[i], cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (cyc !== e.cyc) begin
                        n_err++;
                        $display("FAIL valid_cycle w%0d: got cyc %0d, required %0d", (i == 0) ? 8 : 16, cyc, e.cyc);
                    end
                    n_cmp++;
                    if (gp[i] !== 16'(e.per) || gh[i] !== 16'(e.hi) || gd[i] !== 8'(e.duty) ||
                        gs[i] !== e.stk || (e.stk && gl[i] !== e.lvl)) begin
                        n_err++;
                        $display("FAIL result w%0d: got per=%0d hi=%0d duty=%0d stuck=%b lvl=%b, required per=%0d hi=%0d duty=%0d stuck=%b lvl=%b",
                                 (i == 0) ? 8 : 16, gp[i], gh[i], gd[i], gs[i], gl[i],
                                 e.per, e.hi, e.duty, e.stk, e.lvl);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int hi, input int lo);
        model_rise();
        pwm = 1'b1;
        repeat (hi) tick();
        f_last = cyc;
        pwm = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({if8.period, if8.high_time, if8.duty} !== 24'h0) begin
            n_err++;
            $display("FAIL reset_results8: got %h/%h/%h, required 0", if8.period, if8.high_time, if8.duty);
        end
        n_cmp++;
        if ({if8.valid, if8.stuck, if8.stuck_level, if8.overrun} !== 4'h0) begin
            n_err++;
            $display("FAIL reset_flags8: got %b%b%b%b, required 0000", if8.valid, if8.stuck, if8.stuck_level, if8.overrun);
        end
        n_cmp++;
        if ({if16.period, if16.high_time, if16.duty, if16.valid, if16.stuck, if16.stuck_level, if16.overrun} !== 44'h0) begin
            n_err++;
            $display("FAIL reset_all16: got per=%h hi=%h duty=%h, required all 0", if16.period, if16.high_time, if16.duty);
        end
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_basic();
        model_reset();
        en8 = 1'b1;
        repeat (3) tick();
        pulse(3, 5);
        pulse(3, 5);
        repeat (8) tick();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL basic_missing: got %0d results outstanding, required 0", exp_q.size());
        end
        n_cmp++;
        if (if8.overrun !== exp_ovr || if8.stuck !== 1'b0) begin
            n_err++;
            $display("FAIL basic_flags: got overrun=%b stuck=%b, required %b 0", if8.overrun, if8.stuck, exp_ovr);
        end
        en8 = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_wide();
        model_reset();
        en16 = 1'b1;
        repeat (3) tick();
        repeat (3) pulse(64, 192);
        repeat (16) tick();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL wide_missing: got %0d results outstanding, required 0", exp_q.size());
        end
        n_cmp++;
        if (if16.overrun !== exp_ovr) begin
            n_err++;
            $display("FAIL wide_overrun: got %b, required %b", if16.overrun, exp_ovr);
        end
        en16 = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_stuck();
        exp_t e;
        model_reset();
        en8 = 1'b1;
        repeat (3) tick();
        pulse(3, 5);
        model_rise();
        pwm = 1'b1;
        e.cyc = r_last + IN_LAT + MAX8;
        e.per = 0; e.hi = 0; e.duty = 255; e.stk = 1'b1; e.lvl = 1'b1;
        exp_q.push_back(e);
        armed = 1'b0;
        repeat (270) tick();
        n_cmp++;
        if (if8.stuck !== 1'b1 || if8.stuck_level !== 1'b1) begin
            n_err++;
            $display("FAIL stuck_set: got stuck=%b level=%b, required 1 1", if8.stuck, if8.stuck_level);
        end
        pwm = 1'b0;
        repeat (4) tick();
        model_rise();
        pwm = 1'b1;
        repeat (2) tick();
        n_cmp++;
        if (if8.stuck !== 1'b1) begin
            n_err++;
            $display("FAIL stuck_hold: got stuck=%b before rise detected, required 1", if8.stuck);
        end
        tick();
        n_cmp++;
        if (if8.stuck !== 1'b0) begin
            n_err++;
            $display("FAIL stuck_clear: got stuck=%b after rise, required 0", if8.stuck);
        end
        pwm = 1'b0;
        repeat (3) tick();
        en8 = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL stuck_missing: got %0d results outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_overrun();
        model_reset();
        en8 = 1'b1;
        repeat (3) tick();
        repeat (4) pulse(2, 2);
        repeat (14) tick();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL ovr_missing: got %0d results outstanding, required 0", exp_q.size());
        end
        n_cmp++;
        if (if8.overrun !== exp_ovr) begin
            n_err++;
            $display("FAIL ovr_sticky: got overrun=%b, required %b", if8.overrun, exp_ovr);
        end
        en8 = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if (if8.overrun !== 1'b0 || if8.valid !== 1'b0) begin
            n_err++;
            $display("FAIL ovr_disable: got overrun=%b valid=%b, required 0 0", if8.overrun, if8.valid);
        end
        n_cmp++;
        if (if8.period !== 8'd4 || if8.high_time !== 8'd2 || if8.duty !== 8'd128) begin
            n_err++;
            $display("FAIL ovr_hold: got per=%0d hi=%0d duty=%0d, required 4 2 128", if8.period, if8.high_time, if8.duty);
        end
    endtask

    task automatic test_async_reset();
        model_reset();
        en8 = 1'b1;
        repeat (3) tick();
        pulse(3, 5);
        model_rise();
        pwm = 1'b1;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({if8.period, if8.high_time, if8.duty} !== 24'h0) begin
            n_err++;
            $display("FAIL areset_results: got %h/%h/%h, required 0", if8.period, if8.high_time, if8.duty);
        end
        n_cmp++;
        if ({if8.valid, if8.stuck, if8.stuck_level, if8.overrun} !== 4'h0) begin
            n_err++;
            $display("FAIL areset_flags: got %b%b%b%b, required 0000", if8.valid, if8.stuck, if8.stuck_level, if8.overrun);
        end
        exp_q.delete();
        pwm = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        model_reset();
        repeat (20) tick();
        pulse(3, 5);
        pulse(3, 5);
        repeat (8) tick();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL areset_missing: got %0d results outstanding, required 0", exp_q.size());
        end
        en8 = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_enable_restart();
        model_reset();
        pwm = 1'b1;
        repeat (4) tick();
        en8 = 1'b1;
        repeat (2) tick();
        pwm = 1'b0;
        repeat (5) tick();
        pulse(4, 6);
        pulse(4, 6);
        repeat (8) tick();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL restart_missing: got %0d results outstanding, required 0", exp_q.size());
        end
        n_cmp++;
        if (if8.period !== 8'd10 || if8.duty !== 8'd102) begin
            n_err++;
            $display("FAIL restart_value: got per=%0d duty=%0d, required 10 102", if8.period, if8.duty);
        end
        en8 = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        pwm   = 1'b0;
        en8   = 1'b0;
        en16  = 1'b0;
        r_last = 0;
        f_last = 0;
        model_reset();
        test_reset();
        test_basic();
        test_wide();
        test_stuck();
        test_overrun();
        test_async_reset();
        test_enable_restart();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
